spi_tx_queue: RTL

- Byte-transmit queue sitting directly upstream of SPI_Controller.
- The CPU/bus side pushes bytes into a FIFO. The block pops them one at a time, presents each on spi_value, and issues a start strobe on spi_start (wired to the controller's interrupt input).
- It waits for the controller's busy/done cycle before launching the next byte.
- It reports fill level and a sticky overflow flag back to the bus.

---
 rtl/spi_pkg.sv | 6 +
 rtl/spi_tx_queue_if.sv | 27 ++
 rtl/spi_tx_queue_sync_fifo.sv | 41 ++++
 rtl/spi_tx_queue.sv | 77 +++++++
 4 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state type and constants for the SPI transmit queue.
package spi_pkg;
  localparam int SPI_BYTE_W = 8;
  localparam int DEF_BUSY_TIMEOUT = 64;
  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;
endpackage

// File: rtl/spi_tx_queue_if.sv
// spi_tx_queue_if: bus-side push/status signals plus the controller handshake.
interface spi_tx_queue_if #(
  parameter int DEPTH = 8
);
  import spi_pkg::*;
  localparam int AW = $clog2(DEPTH);
  logic wr_en;
  logic [SPI_BYTE_W-1:0] wr_data;
  logic flush;
  logic spi_busy;
  logic [SPI_BYTE_W-1:0] spi_value;
  logic spi_start;
  logic full;
  logic empty;
  logic [AW:0] count;
  logic overflow;
  logic timeout;
  logic idle;
  modport master (
    output wr_en, wr_data, flush, spi_busy,
    input  spi_value, spi_start, full, empty, count, overflow, timeout, idle
  );
  modport slave (
    input  wr_en, wr_data, flush, spi_busy,
    output spi_value, spi_start, full, empty, count, overflow, timeout, idle
  );
endinterface

// File: rtl/spi_tx_queue_sync_fifo.sv
// sync_fifo: power-of-two FIFO; the extra pointer bit separates full from empty.
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic push,
  input  logic pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic full,
  output logic empty,
  output logic [AW:0] count
);
  localparam int PW = AW + 1;
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  assign count = wr_ptr - rd_ptr;
  assign full = count == PW'(DEPTH);
  assign empty = count == '0;
  assign push_ok = push && !full && !clr;
  assign pop_ok = pop && !empty && !clr;
  assign rdata = mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push_ok);
      rd_ptr <= rd_ptr + PW'(pop_ok);
    end
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr[AW-1:0]] <= wdata;
endmodule

// File: rtl/spi_tx_queue.sv
// spi_tx_queue: byte FIFO feeding an SPI controller, one start strobe per byte.
module spi_tx_queue
  import spi_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH),
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input logic clk,
  input logic rst_n,
  spi_tx_queue_if.slave bus
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  state_t state, state_n;
  logic [TW-1:0] cnt, cnt_n;
  logic [SPI_BYTE_W-1:0] rd_data;
  logic [AW:0] count;
  logic launch, expire, full, empty;
  sync_fifo #(.W(SPI_BYTE_W), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .clr(bus.flush),
    .push(bus.wr_en),
    .pop(launch),
    .wdata(bus.wr_data),
    .rdata(rd_data),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign bus.full = full;
  assign bus.empty = empty;
  assign bus.count = count;
  assign bus.spi_start = state == START;
  assign bus.idle = state == IDLE && empty;
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    launch = 1'b0;
    expire = 1'b0;
    case (state)
      IDLE:
        if (!empty && !bus.spi_busy && !bus.flush) begin
          launch = 1'b1;
          state_n = START;
        end
      START: begin
        cnt_n = TW'(BUSY_TIMEOUT);
        state_n = WAIT_BUSY;
      end
      WAIT_BUSY:
        if (bus.spi_busy) state_n = WAIT_DONE;
        else begin
          cnt_n = cnt - TW'(1);
          expire = cnt == TW'(1);
          state_n = expire ? IDLE : WAIT_BUSY;
        end
      WAIT_DONE: state_n = bus.spi_busy ? WAIT_DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // flush clears the sticky flags but leaves the in-flight byte and FSM alone
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      bus.spi_value <= '0;
      bus.overflow <= 1'b0;
      bus.timeout <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (launch) bus.spi_value <= rd_data;
      bus.overflow <= !bus.flush && (bus.overflow || (bus.wr_en && full));
      bus.timeout <= !bus.flush && (bus.timeout || expire);
    end
endmodule
